// File: rtl/block_sync.sv
// block_sync: 66b block-alignment stage. Checks sync headers, runs the
// block-lock FSM, asks the gearbox for bit slips while hunting, and forwards
// aligned (still scrambled) blocks with a valid qualifier once locked.
//
//  state        | meaning
//  -------------+-----------------------------------------------------------
//  ST_HUNT      | counting consecutive valid headers towards lock
//  ST_SLIP_HOLD | slip requested; ignoring SLIP_WAIT blocks while gearbox settles
//  ST_LOCKED    | aligned; monitoring invalid headers per WINDOW blocks
module block_sync #(
    parameter int LEN_CODED_BLOCK = 66,
    parameter int LOCK_COUNT      = 64,
    parameter int WINDOW          = 1024,
    parameter int MAX_INVALID     = 65,
    parameter int SLIP_WAIT       = 4
) (
    input  logic                       i_clock,
    input  logic                       i_reset_n,
    input  logic                       i_enable,
    input  logic [LEN_CODED_BLOCK-1:0] i_data,
    output logic [LEN_CODED_BLOCK-1:0] o_data,
    output logic                       o_valid,
    output logic                       o_block_lock,
    output logic                       o_slip,
    output logic                       o_sh_invalid
);

    localparam int SH_W  = $clog2(LOCK_COUNT + 1);
    localparam int WIN_W = $clog2(WINDOW + 1);
    localparam int INV_W = $clog2(MAX_INVALID + 1);
    localparam int HLD_W = $clog2(SLIP_WAIT + 1);

    typedef enum logic [1:0] {
        ST_HUNT      = 2'd0,
        ST_SLIP_HOLD = 2'd1,
        ST_LOCKED    = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [SH_W-1:0]    sh_cnt, sh_cnt_nxt;
    logic [WIN_W-1:0]   win_cnt, win_cnt_nxt, win_inc;
    logic [INV_W-1:0]   inv_cnt, inv_cnt_nxt, inv_inc;
    logic [HLD_W-1:0]   hold_cnt, hold_cnt_nxt;
    logic               slip_nxt;
    logic               valid_nxt;
    logic [1:0]         sh;
    logic               sh_bad;

    assign sh     = i_data[LEN_CODED_BLOCK-1 -: 2];
    assign sh_bad = (sh == 2'b00) || (sh == 2'b11);

    // Lock status is simply the registered state, so it rises one cycle
    // after the locking block and falls together with the lock-loss slip.
    assign o_block_lock = (state == ST_LOCKED);

    // Next-state and counter logic; nothing moves unless a block is enabled.
    always_comb begin
        state_nxt    = state;
        sh_cnt_nxt   = sh_cnt;
        win_cnt_nxt  = win_cnt;
        inv_cnt_nxt  = inv_cnt;
        hold_cnt_nxt = hold_cnt;
        slip_nxt     = 1'b0;
        valid_nxt    = 1'b0;
        win_inc      = win_cnt + WIN_W'(1);
        inv_inc      = inv_cnt + INV_W'(sh_bad);

        if (i_enable) begin
            unique case (state)
                ST_HUNT: begin
                    if (sh_bad) begin
                        slip_nxt     = 1'b1;
                        sh_cnt_nxt   = '0;
                        hold_cnt_nxt = HLD_W'(SLIP_WAIT);
                        state_nxt    = ST_SLIP_HOLD;
                    end else if (sh_cnt == SH_W'(LOCK_COUNT - 1)) begin
                        sh_cnt_nxt  = '0;
                        win_cnt_nxt = '0;
                        inv_cnt_nxt = '0;
                        state_nxt   = ST_LOCKED;
                    end else begin
                        sh_cnt_nxt = sh_cnt + SH_W'(1);
                    end
                end

                ST_SLIP_HOLD: begin
                    // Down-counter: headers are ignored until it expires.
                    if (hold_cnt <= HLD_W'(1)) begin
                        hold_cnt_nxt = '0;
                        sh_cnt_nxt   = '0;
                        state_nxt    = ST_HUNT;
                    end else begin
                        hold_cnt_nxt = hold_cnt - HLD_W'(1);
                    end
                end

                ST_LOCKED: begin
                    win_cnt_nxt = win_inc;
                    inv_cnt_nxt = inv_inc;
                    // Loss of lock is checked first so it wins over rollover.
                    if (inv_inc == INV_W'(MAX_INVALID)) begin
                        slip_nxt     = 1'b1;
                        sh_cnt_nxt   = '0;
                        win_cnt_nxt  = '0;
                        inv_cnt_nxt  = '0;
                        hold_cnt_nxt = HLD_W'(SLIP_WAIT);
                        state_nxt    = ST_SLIP_HOLD;
                    end else begin
                        valid_nxt = 1'b1;
                        if (win_inc == WIN_W'(WINDOW)) begin
                            win_cnt_nxt = '0;
                            inv_cnt_nxt = '0;
                        end
                    end
                end

                default: begin
                    state_nxt = ST_HUNT;
                end
            endcase
        end
    end

    // State and counter registers.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state    <= ST_HUNT;
            sh_cnt   <= '0;
            win_cnt  <= '0;
            inv_cnt  <= '0;
            hold_cnt <= '0;
        end else begin
            state    <= state_nxt;
            sh_cnt   <= sh_cnt_nxt;
            win_cnt  <= win_cnt_nxt;
            inv_cnt  <= inv_cnt_nxt;
            hold_cnt <= hold_cnt_nxt;
        end
    end

    // Output register: one-cycle latency for data and the per-block flags.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_data       <= '0;
            o_valid      <= 1'b0;
            o_slip       <= 1'b0;
            o_sh_invalid <= 1'b0;
        end else begin
            if (i_enable) begin
                o_data <= i_data;
            end
            o_valid      <= valid_nxt;
            o_slip       <= slip_nxt;
            o_sh_invalid <= i_enable & sh_bad;
        end
    end

endmodule

// File: doc/block_sync.md
# block_sync

Receive-side 66b block-alignment stage that sits directly upstream of the descrambler. It checks the 2-bit sync header of every incoming coded block, runs the block-lock state machine, requests a one-bit slip from the gearbox while hunting, and forwards aligned blocks (still scrambled) with a valid qualifier once lock is achieved.

## Interface

Parameters:
- LEN_CODED_BLOCK, 66: coded block width; the sync header is bits [LEN_CODED_BLOCK-1 -: 2].
- LOCK_COUNT, 64: number of consecutive valid headers required to declare lock.
- WINDOW, 1024: number of evaluated blocks in the monitoring window while locked.
- MAX_INVALID, 65: number of invalid headers inside one window that forces loss of lock.
- SLIP_WAIT, 4: number of enabled blocks ignored after each slip request.

Ports:
- i_clock, in, 1: the block's single clock.
- i_reset_n, in, 1: reset, asynchronous and active-low.
- i_enable, in, 1: i_data holds a new block this cycle.
- i_data, in, LEN_CODED_BLOCK: candidate coded block from the gearbox.
- o_data, out, LEN_CODED_BLOCK: registered copy of the last enabled i_data.
- o_valid, out, 1: o_data is an aligned block accepted while locked.
- o_block_lock, out, 1: block lock status.
- o_slip, out, 1: one-cycle pulse requesting a one-bit slip of the gearbox alignment.
- o_sh_invalid, out, 1: one-cycle flag for the registered block having an invalid header.

## Operation

- Header valid ⇔ i_data[65:64] ∈ {2'b01, 2'b10}. 2'b00 and 2'b11 are invalid.
- Only cycles with i_enable=1 are evaluated. With i_enable=0, all counters and state hold, and o_valid, o_slip and o_sh_invalid are 0.
- The FSM has three states: HUNT, SLIP_HOLD and LOCKED. After reset the FSM is in HUNT.
- HUNT:
  - A valid header increments sh_cnt.
  - On the LOCK_COUNT-th consecutive valid header, the FSM moves to LOCKED and clears sh_cnt, win_cnt and inv_cnt.
  - An invalid header pulses o_slip, clears sh_cnt and moves to SLIP_HOLD.
- SLIP_HOLD:
  - Counts SLIP_WAIT enabled blocks, ignoring their headers (o_sh_invalid is still reported).
  - After the SLIP_WAIT-th block, returns to HUNT with sh_cnt=0.
- LOCKED:
  - Every enabled block increments win_cnt. Every invalid header increments inv_cnt.
  - If inv_cnt reaches MAX_INVALID: pulse o_slip, drop lock, clear all counters and go to SLIP_HOLD.
  - Otherwise, if win_cnt reaches WINDOW: clear win_cnt and inv_cnt and stay LOCKED.
  - Lock loss has priority over window rollover when both occur on the same block.
- o_valid=1 for a block evaluated in LOCKED that did not cause loss of lock, including blocks with invalid headers. The downstream decoder handles those.
- Counter widths are $clog2(param+1). Counters never wrap; they are cleared explicitly as described above.
- The first 66b block received during a slip settle period is not forwarded as valid.

## Timing

- Reset: async assert, sync deassert via the clock. All outputs are 0 and all counters are 0.
- Latency: one cycle. o_data, o_valid, o_sh_invalid and o_slip all reflect the block enabled in the previous cycle.
- o_block_lock rises in the cycle after the LOCK_COUNT-th valid block. That block itself has o_valid=0; the next enabled block gets o_valid=1.
- o_block_lock falls in the same cycle that o_slip pulses for the lock-loss block, and o_valid=0 for that block.
- o_slip is never high for two consecutive enabled blocks. At least SLIP_WAIT+1 enabled blocks separate two pulses.
- Reset asserted mid-operation takes effect immediately: lock and outputs drop asynchronously and no slip is issued.

## Test plan

- Reset, then 64 blocks with header 2'b01 on consecutive cycles → o_block_lock=1 in the cycle after the 64th block; o_valid=1 for block 65 onward; o_slip never asserted.
- 63 valid blocks, then one 2'b00 → o_slip=1 for exactly one cycle, lock stays 0. The next 4 enabled blocks are ignored even if invalid, then 64 fresh valid blocks → lock.
- Locked; inject 64 invalid headers spread over 1024 blocks → lock held, counters cleared at the window end. In the next window, 65 invalid within 1024 → lock drops with an o_slip pulse on the 65th.
- Locked; the 65th invalid header arrives exactly on the 1024th block of the window → lock lost, o_slip=1 (loss beats rollover).
- Hunting with i_enable toggling 1/0 every cycle, 64 valid enabled blocks → lock after the 64th enabled block (128 cycles); disabled cycles are not counted.
- Locked, i_reset_n pulsed low for 1 cycle mid-stream → o_block_lock, o_valid and o_slip are 0 immediately; relock requires 64 new valid blocks.
